// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: bundle of pipeline, MDU and regfile write-port signals for wb_write_arbiter
//   pl_we/pl_wn/pl_d        pipeline WB write request
//   md_issue/md_issue_rd    MDU op issue (destination marked busy)
//   md_valid/md_wn/md_d     MDU result, accepted when md_ready
//   md_ready                MDU result queue has room
//   rf_we/rf_wn/rf_d        registered regfile write port
//   busy/waw_err            outstanding-MDU scoreboard and WAW pulse
interface wb_write_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          pl_we;
    logic [AW-1:0] pl_wn;
    logic [DW-1:0] pl_d;
    logic          md_issue;
    logic [AW-1:0] md_issue_rd;
    logic          md_valid;
    logic [AW-1:0] md_wn;
    logic [DW-1:0] md_d;
    logic          md_ready;
    logic          rf_we;
    logic [AW-1:0] rf_wn;
    logic [DW-1:0] rf_d;
    logic [31:0]   busy;
    logic          waw_err;
    modport master (
        output pl_we, pl_wn, pl_d, md_issue, md_issue_rd, md_valid, md_wn, md_d,
        input  md_ready, rf_we, rf_wn, rf_d, busy, waw_err
    );
    modport slave (
        input  pl_we, pl_wn, pl_d, md_issue, md_issue_rd, md_valid, md_wn, md_d,
        output md_ready, rf_we, rf_wn, rf_d, busy, waw_err
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges pipeline WB and queued MDU results into one registered regfile write per cycle
//   clk   clock, posedge
//   clrn  asynchronous active-low reset
//   bus   wb_write_arbiter_if slave: pipeline/MDU inputs, md_ready, rf_* write port, busy scoreboard, waw_err
module wb_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input logic               clk,
    input logic               clrn,
    wb_write_arbiter_if.slave bus
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [AW-1:0] q_wn [DEPTH];
    logic [DW-1:0] q_d  [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          pl_act, enq, pop;
    logic [31:0]   set_mask, clr_mask, busy_nxt;
    assign pl_act       = bus.pl_we && bus.pl_wn != '0;
    assign bus.md_ready = count < FULL;
    // results addressed to r0 complete the handshake but never occupy a slot
    assign enq          = bus.md_valid && bus.md_ready && bus.md_wn != '0;
    // pipeline always has priority; the queue drains only on idle pipeline cycles
    assign pop          = !pl_act && count != '0;
    assign count_nxt    = (enq && !pop) ? count + CW'(1) : (!enq && pop) ? count - CW'(1) : count;
    assign set_mask     = (bus.md_issue && bus.md_issue_rd != '0) ? 32'd1 << bus.md_issue_rd : '0;
    assign clr_mask     = pop ? 32'd1 << q_wn[rd_ptr] : '0;
    // set applied after clear so a re-issue in the pop cycle keeps the bit
    assign busy_nxt     = ((bus.busy & ~clr_mask) | set_mask) & ~32'd1;
    always_ff @(posedge clk) begin
        if (enq) begin
            q_wn[wr_ptr] <= bus.md_wn;
            q_d[wr_ptr]  <= bus.md_d;
        end
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bus.busy    <= '0;
            bus.rf_we   <= 1'b0;
            bus.rf_wn   <= '0;
            bus.rf_d    <= '0;
            bus.waw_err <= 1'b0;
        end else begin
            wr_ptr      <= enq ? (wr_ptr == LAST ? '0 : wr_ptr + PW'(1)) : wr_ptr;
            rd_ptr      <= pop ? (rd_ptr == LAST ? '0 : rd_ptr + PW'(1)) : rd_ptr;
            count       <= count_nxt;
            bus.busy    <= busy_nxt;
            bus.rf_we   <= pl_act || pop;
            bus.waw_err <= pl_act && bus.busy[bus.pl_wn];
            if (pl_act || pop) begin
                bus.rf_wn <= pl_act ? bus.pl_wn : q_wn[rd_ptr];
                bus.rf_d  <= pl_act ? bus.pl_d : q_d[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: scoreboard bench for wb_write_arbiter with DEPTH=2
module tb_wb_write_arbiter;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;
    wb_write_arbiter_if #(.DW(32), .AW(5)) bus ();
    wb_write_arbiter #(.DEPTH(2), .DW(32), .AW(5)) dut (.clk(clk), .clrn(clrn), .bus(bus));
    typedef struct packed {
        logic [4:0]  wn;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int  n_chk = 0;
    int  n_fail = 0;
    // every regfile write must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (clrn && bus.rf_we) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got wn=%0d d=%h, required no write", bus.rf_wn, bus.rf_d);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rf_wn !== mon_e.wn || bus.rf_d !== mon_e.d) begin
                    n_fail++;
                    $display("FAIL sb_write: got wn=%0d d=%h, required wn=%0d d=%h", bus.rf_wn, bus.rf_d, mon_e.wn, mon_e.d);
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.pl_we = 1'b0; bus.pl_wn = '0; bus.pl_d = '0;
        bus.md_issue = 1'b0; bus.md_issue_rd = '0;
        bus.md_valid = 1'b0; bus.md_wn = '0; bus.md_d = '0;
    endtask
    task automatic pl(input logic [4:0] wn, input logic [31:0] d);
        bus.pl_we = 1'b1; bus.pl_wn = wn; bus.pl_d = d;
        if (wn != 5'd0) exp_q.push_back({wn, d});
    endtask
    task automatic md(input logic [4:0] wn, input logic [31:0] d);
        bus.md_valid = 1'b1; bus.md_wn = wn; bus.md_d = d;
    endtask
    task automatic push(input logic [4:0] wn, input logic [31:0] d);
        exp_q.push_back({wn, d});
    endtask
    task automatic test_reset();
        clrn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.pl_we = 1'($urandom); bus.pl_wn = 5'($urandom); bus.pl_d = $urandom;
            bus.md_issue = 1'($urandom); bus.md_issue_rd = 5'($urandom);
            bus.md_valid = 1'($urandom); bus.md_wn = 5'($urandom); bus.md_d = $urandom;
            tick();
            n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b, required 0", bus.rf_we); end
            n_chk++; if (bus.busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h, required 0", bus.busy); end
            n_chk++; if (bus.waw_err !== 1'b0) begin n_fail++; $display("FAIL reset_waw: got %b, required 0", bus.waw_err); end
        end
        idle();
        clrn = 1'b1;
        #1;
        n_chk++; if (bus.md_ready !== 1'b1) begin n_fail++; $display("FAIL reset_md_ready: got %b, required 1", bus.md_ready); end
        n_chk++; if (bus.rf_wn !== 5'd0 || bus.rf_d !== 32'd0) begin n_fail++; $display("FAIL reset_rf: got wn=%0d d=%h, required 0/0", bus.rf_wn, bus.rf_d); end
        tick();
        n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_idle_we: got %b, required 0", bus.rf_we); end
    endtask
    task automatic test_pipeline();
        pl(5'd5, 32'hDEADBEEF);
        tick();
        n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_wn !== 5'd5 || bus.rf_d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pl_write: got we=%b wn=%0d d=%h, required 1/5/deadbeef", bus.rf_we, bus.rf_wn, bus.rf_d); end
        pl(5'd0, 32'h1234);
        tick();
        n_chk++; if (bus.rf_we !== 1'b0 || bus.rf_wn !== 5'd5 || bus.rf_d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pl_r0: got we=%b wn=%0d d=%h, required 0/5/deadbeef", bus.rf_we, bus.rf_wn, bus.rf_d); end
        idle();
    endtask
    task automatic test_contention();
        bus.md_issue = 1'b1; bus.md_issue_rd = 5'd7;
        tick();
        idle();
        n_chk++; if (bus.busy !== 32'h80) begin n_fail++; $display("FAIL cont_busy_set: got %h, required 80", bus.busy); end
        pl(5'd3, 32'h33);
        md(5'd7, 32'h12);
        push(5'd7, 32'h12);
        tick();
        idle();
        n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_wn !== 5'd3) begin n_fail++; $display("FAIL cont_pl_first: got we=%b wn=%0d, required 1/3", bus.rf_we, bus.rf_wn); end
        n_chk++; if (bus.busy !== 32'h80) begin n_fail++; $display("FAIL cont_busy_hold: got %h, required 80", bus.busy); end
        tick();
        n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_wn !== 5'd7 || bus.rf_d !== 32'h12) begin n_fail++; $display("FAIL cont_md_next: got we=%b wn=%0d d=%h, required 1/7/12", bus.rf_we, bus.rf_wn, bus.rf_d); end
        n_chk++; if (bus.busy !== 32'd0) begin n_fail++; $display("FAIL cont_busy_clr: got %h, required 0", bus.busy); end
        tick();
        n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL cont_idle: got %b, required 0", bus.rf_we); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cont_drain: got %0d pending, required 0", exp_q.size()); end
    endtask
    task automatic test_full_queue();
        bus.md_issue = 1'b1;
        for (int i = 10; i < 13; i++) begin
            bus.md_issue_rd = 5'(i);
            tick();
        end
        idle();
        n_chk++; if (bus.busy !== 32'h1C00) begin n_fail++; $display("FAIL full_busy: got %h, required 1c00", bus.busy); end
        pl(5'd1, 32'h101); md(5'd10, 32'hA0);
        tick();
        n_chk++; if (bus.md_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready1: got %b, required 1", bus.md_ready); end
        pl(5'd2, 32'h102); md(5'd11, 32'hA1);
        tick();
        n_chk++; if (bus.md_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready2: got %b, required 0", bus.md_ready); end
        pl(5'd4, 32'h104); md(5'd12, 32'hA2);
        tick();
        n_chk++; if (bus.md_ready !== 1'b0 || bus.rf_wn !== 5'd4) begin n_fail++; $display("FAIL full_held: got ready=%b wn=%0d, required 0/4", bus.md_ready, bus.rf_wn); end
        bus.pl_we = 1'b0;
        push(5'd10, 32'hA0); push(5'd11, 32'hA1); push(5'd12, 32'hA2);
        tick();
        n_chk++; if (bus.rf_wn !== 5'd10 || bus.md_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop1: got wn=%0d ready=%b, required 10/1", bus.rf_wn, bus.md_ready); end
        n_chk++; if (bus.busy !== 32'h1800) begin n_fail++; $display("FAIL full_busy1: got %h, required 1800", bus.busy); end
        tick();
        idle();
        n_chk++; if (bus.rf_wn !== 5'd11 || bus.busy !== 32'h1000 || bus.md_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop2: got wn=%0d busy=%h ready=%b, required 11/1000/1", bus.rf_wn, bus.busy, bus.md_ready); end
        tick();
        n_chk++; if (bus.rf_wn !== 5'd12 || bus.busy !== 32'd0) begin n_fail++; $display("FAIL full_pop3: got wn=%0d busy=%h, required 12/0", bus.rf_wn, bus.busy); end
        tick();
        n_chk++; if (bus.rf_we !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain: got we=%b pending=%0d, required 0/0", bus.rf_we, exp_q.size()); end
    endtask
    task automatic test_simultaneous();
        pl(5'd5, 32'h55); md(5'd13, 32'hB0);
        tick();
        n_chk++; if (bus.md_ready !== 1'b1 || bus.rf_wn !== 5'd5) begin n_fail++; $display("FAIL sim_fill: got ready=%b wn=%0d, required 1/5", bus.md_ready, bus.rf_wn); end
        bus.pl_we = 1'b0;
        md(5'd14, 32'hB1); push(5'd13, 32'hB0);
        tick();
        n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_wn !== 5'd13 || bus.md_ready !== 1'b1) begin n_fail++; $display("FAIL sim_swap1: got we=%b wn=%0d ready=%b, required 1/13/1", bus.rf_we, bus.rf_wn, bus.md_ready); end
        md(5'd15, 32'hB2); push(5'd14, 32'hB1);
        tick();
        n_chk++; if (bus.rf_wn !== 5'd14 || bus.rf_d !== 32'hB1 || bus.md_ready !== 1'b1) begin n_fail++; $display("FAIL sim_swap2: got wn=%0d d=%h ready=%b, required 14/b1/1", bus.rf_wn, bus.rf_d, bus.md_ready); end
        md(5'd0, 32'hFFFF); push(5'd15, 32'hB2);
        tick();
        idle();
        n_chk++; if (bus.rf_wn !== 5'd15 || bus.rf_d !== 32'hB2) begin n_fail++; $display("FAIL sim_last: got wn=%0d d=%h, required 15/b2", bus.rf_wn, bus.rf_d); end
        tick();
        n_chk++; if (bus.rf_we !== 1'b0 || bus.md_ready !== 1'b1 || exp_q.size() != 0) begin n_fail++; $display("FAIL sim_r0_drop: got we=%b ready=%b pending=%0d, required 0/1/0", bus.rf_we, bus.md_ready, exp_q.size()); end
    endtask
    task automatic test_waw_reset();
        bus.md_issue = 1'b1; bus.md_issue_rd = 5'd9;
        tick();
        idle();
        n_chk++; if (bus.busy !== 32'h200) begin n_fail++; $display("FAIL waw_busy: got %h, required 200", bus.busy); end
        pl(5'd9, 32'h99);
        tick();
        idle();
        n_chk++; if (bus.waw_err !== 1'b1 || bus.rf_wn !== 5'd9 || bus.busy !== 32'h200) begin n_fail++; $display("FAIL waw_pulse: got waw=%b wn=%0d busy=%h, required 1/9/200", bus.waw_err, bus.rf_wn, bus.busy); end
        tick();
        n_chk++; if (bus.waw_err !== 1'b0) begin n_fail++; $display("FAIL waw_one_cycle: got %b, required 0", bus.waw_err); end
        bus.md_issue = 1'b1; bus.md_issue_rd = 5'd20; pl(5'd2, 32'h1);
        tick();
        bus.md_issue_rd = 5'd21; md(5'd20, 32'hC0); pl(5'd2, 32'h2);
        tick();
        bus.md_issue = 1'b0; md(5'd21, 32'hC1); pl(5'd2, 32'h3);
        tick();
        idle();
        n_chk++; if (bus.md_ready !== 1'b0 || bus.busy !== 32'h0030_0200) begin n_fail++; $display("FAIL rst_pre: got ready=%b busy=%h, required 0/00300200", bus.md_ready, bus.busy); end
        clrn = 1'b0;
        #1;
        n_chk++; if (bus.busy !== 32'd0 || bus.md_ready !== 1'b1 || bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_async: got busy=%h ready=%b we=%b, required 0/1/0", bus.busy, bus.md_ready, bus.rf_we); end
        tick();
        tick();
        clrn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_discard: got we=%b wn=%0d, required 0", bus.rf_we, bus.rf_wn); end
        end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_drain: got %0d pending, required 0", exp_q.size()); end
    endtask
    initial begin
        idle();
        test_reset();
        test_pipeline();
        test_contention();
        test_full_queue();
        test_simultaneous();
        test_waw_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
